// File: rtl/dcache_pkg.sv
// Shared types for the N-way D-cache datapath: write-enable modes, mux selects
// and flush sequencer states.
package dcache_pkg;

  typedef enum logic [1:0] {
    WE_ZEROS = 2'd0,
    WE_ONES  = 2'd1,
    WE_MBE   = 2'd2
  } we_mode_e;

  typedef enum logic {
    DSRC_CPU = 1'b0,
    DSRC_MEM = 1'b1
  } data_src_e;

  typedef enum logic {
    ASRC_CPU = 1'b0,
    ASRC_TAG = 1'b1
  } addr_src_e;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_SCAN = 2'd1,
    FL_WB   = 2'd2,
    FL_DONE = 2'd3
  } flush_state_e;

endpackage

// File: rtl/dcache_plru_tree.sv
// Tree-PLRU for one set: next-state bits after an access and the current victim.
// Level d of the tree splits on way bit d; a node bit names the side to evict.
module dcache_plru_tree #(
  parameter  int NUM_WAYS = 4,
  localparam int W_IDX    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] bits_i,
  input  logic [W_IDX-1:0]    acc_way_i,
  output logic [NUM_WAYS-2:0] next_bits_o,
  output logic [W_IDX-1:0]    victim_o
);

  // Padded to NUM_WAYS so a W_IDX-bit node index always lands inside the vector.
  logic [NUM_WAYS-1:0] cur, nxt;
  logic [W_IDX-1:0]    node, vnode;
  logic                bit_v;

  assign cur = {1'b0, bits_i};

  always_comb begin
    nxt  = cur;
    node = '0;
    for (int d = 0; d < W_IDX; d++) begin
      nxt[node] = ~acc_way_i[d];
      node      = W_IDX'(2 * int'(node) + 1 + int'(acc_way_i[d]));
    end
  end

  always_comb begin
    victim_o = '0;
    vnode    = '0;
    bit_v    = 1'b0;
    for (int d = 0; d < W_IDX; d++) begin
      bit_v       = cur[vnode];
      victim_o[d] = bit_v;
      vnode       = W_IDX'(2 * int'(vnode) + 1 + int'(bit_v));
    end
  end

  assign next_bits_o = nxt[NUM_WAYS-2:0];

  logic unused_pad;
  assign unused_pad = nxt[NUM_WAYS-1];

endmodule

// File: rtl/dcache_nway_datapath.sv
// N-way set-associative D-cache datapath with tree-PLRU and a dirty-line flush
// sequencer. Define DCACHE_PERF_CNT_EN to build the hit/miss counters.
module dcache_nway_datapath
  import dcache_pkg::*;
#(
  parameter  int S_OFFSET = 5,
  parameter  int S_INDEX  = 3,
  parameter  int NUM_WAYS = 4,
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX,
  localparam int S_MASK   = 2**S_OFFSET,
  localparam int S_LINE   = 8 * S_MASK,
  localparam int W_IDX    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         address_i,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [S_MASK-1:0]   mem_byte_enable256,
  input  logic [S_LINE-1:0]   mem_wdata256,
  output logic [S_LINE-1:0]   mem_rdata256,
  input  logic [S_LINE-1:0]   pmem_rdata,
  output logic [S_LINE-1:0]   pmem_wdata,
  output logic [31:0]         pmem_address,
  input  logic [W_IDX-1:0]    way_sel,
  input  logic                data_src,
  input  logic [1:0]          we_mode,
  input  logic                addr_src,
  input  logic                meta_load,
  input  logic                valid_i,
  input  logic                dirty_i,
  output logic [NUM_WAYS-1:0] hit_o,
  output logic                hit_any,
  output logic [W_IDX-1:0]    hit_way,
  output logic [W_IDX-1:0]    victim_way,
  output logic                victim_dirty,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                flush_wb_req,
  input  logic                flush_wb_ack,
  output logic                flush_done,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int NUM_SETS = 2**S_INDEX;

  flush_state_e         state_q, state_d;
  logic [S_INDEX-1:0]   flush_set_q, flush_set_d;
  logic [W_IDX-1:0]     flush_way_q, flush_way_d;
  logic                 busy;

  logic [S_LINE-1:0]    data_q [NUM_WAYS][NUM_SETS];
  logic [S_TAG-1:0]     tag_q  [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, dirty_q;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru_q;

  logic [S_INDEX-1:0]   set_idx;
  logic [S_TAG-1:0]     addr_tag;
  logic [W_IDX-1:0]     eff_way;
  logic [S_LINE-1:0]    rd_line, wr_line;
  logic [S_MASK-1:0]    byte_we;

  assign busy       = (state_q != FL_IDLE);
  assign flush_busy = busy;
  assign set_idx    = busy ? flush_set_q : address_i[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign addr_tag   = address_i[31 -: S_TAG];
  assign eff_way    = busy ? flush_way_q : way_sel;

  // ---------------- hit detection ----------------
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_hit
    assign hit_o[w] = !busy && valid_q[set_idx][w] && (tag_q[w][set_idx] == addr_tag);
  end

  assign hit_any = |hit_o;

  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (hit_o[w]) hit_way = W_IDX'(w);
  end

  // ---------------- line muxing ----------------
  assign rd_line      = data_q[eff_way][set_idx];
  assign mem_rdata256 = rd_line;
  assign pmem_wdata   = rd_line;
  assign pmem_address = (busy || addr_src == ASRC_TAG)
                      ? {tag_q[eff_way][set_idx], set_idx, {S_OFFSET{1'b0}}}
                      : {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};

  assign wr_line = (data_src == DSRC_MEM) ? pmem_rdata : mem_wdata256;

  always_comb begin
    byte_we = '0;
    if (!busy) begin
      case (we_mode_e'(we_mode))
        WE_ONES: byte_we = '1;
        WE_MBE:  byte_we = mem_byte_enable256;
        default: byte_we = '0;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    for (int b = 0; b < S_MASK; b++)
      if (byte_we[b]) data_q[way_sel][set_idx][8*b +: 8] <= wr_line[8*b +: 8];
    if (!busy && meta_load) tag_q[way_sel][set_idx] <= addr_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (!busy && meta_load) begin
        valid_q[set_idx][way_sel] <= valid_i;
        dirty_q[set_idx][way_sel] <= dirty_i;
      end
      if (state_q == FL_WB && flush_wb_ack) dirty_q[flush_set_q][flush_way_q] <= 1'b0;
    end
  end

  // ---------------- PLRU ----------------
  logic                pend_vld_q;
  logic [S_INDEX-1:0]  pend_set_q;
  logic [NUM_WAYS-2:0] pend_bits_q;
  logic [NUM_WAYS-2:0] plru_cur, plru_nxt;
  logic [W_IDX-1:0]    tree_victim;
  logic                plru_upd;

  // The update is one cycle behind the access, so forward it to same-set reads.
  assign plru_cur = (pend_vld_q && pend_set_q == set_idx) ? pend_bits_q : plru_q[set_idx];
  assign plru_upd = (mem_read | mem_write) && hit_any;

  dcache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .bits_i      (plru_cur),
    .acc_way_i   (hit_way),
    .next_bits_o (plru_nxt),
    .victim_o    (tree_victim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plru_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_set_q  <= '0;
      pend_bits_q <= '0;
    end else begin
      pend_vld_q <= plru_upd;
      if (plru_upd) begin
        pend_set_q  <= set_idx;
        pend_bits_q <= plru_nxt;
      end
      if (pend_vld_q) plru_q[pend_set_q] <= pend_bits_q;
    end
  end

  always_comb begin
    victim_way = tree_victim;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[set_idx][w]) victim_way = W_IDX'(w);
  end

  assign victim_dirty = valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way];

  // ---------------- flush sequencer ----------------
  logic [NUM_WAYS-1:0] scan_vec;
  logic [W_IDX-1:0]    scan_way;

  assign scan_vec = valid_q[set_idx] & dirty_q[set_idx];

  always_comb begin
    scan_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (scan_vec[w]) scan_way = W_IDX'(w);
  end

  always_comb begin
    state_d      = state_q;
    flush_set_d  = flush_set_q;
    flush_way_d  = flush_way_q;
    flush_wb_req = 1'b0;
    flush_done   = 1'b0;
    case (state_q)
      FL_IDLE: if (flush_req) begin
        state_d     = FL_SCAN;
        flush_set_d = '0;
      end
      FL_SCAN: begin
        if (|scan_vec) begin
          flush_way_d = scan_way;
          state_d     = FL_WB;
        end else if (flush_set_q == {S_INDEX{1'b1}}) begin
          state_d = FL_DONE;
        end else begin
          flush_set_d = flush_set_q + 1'b1;
        end
      end
      FL_WB: begin
        flush_wb_req = 1'b1;
        if (flush_wb_ack) state_d = FL_SCAN;
      end
      FL_DONE: begin
        flush_done = 1'b1;
        state_d    = FL_IDLE;
      end
      default: state_d = FL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FL_IDLE;
      flush_set_q <= '0;
      flush_way_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_set_q <= flush_set_d;
      flush_way_q <= flush_way_d;
    end
  end

  // ---------------- performance counters ----------------
`ifdef DCACHE_PERF_CNT_EN
  logic        req_q;
  logic        req_start;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign req_start = (mem_read | mem_write) && !req_q && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      req_q <= mem_read | mem_write;
      if (req_start && hit_any && hit_cnt_q != 32'hFFFF_FFFF)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (req_start && !hit_any && miss_cnt_q != 32'hFFFF_FFFF)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  logic unused_addr;
  assign unused_addr = ^address_i[S_OFFSET-1:0];

endmodule

// File: tb/tb_dcache_nway_datapath.sv
// Randomised self-checking bench for dcache_nway_datapath against a behavioural
// cache model (arrays of lines/tags, prefix-indexed PLRU history, flush list).
module tb_dcache_nway_datapath;

  localparam int NW = 4, NS = 8, WI = 2, SL = 256, SM = 32;

  logic           clk = 1'b0, rst = 1'b1;
  logic [31:0]    address_i = '0;
  logic           mem_read = 0, mem_write = 0;
  logic [SM-1:0]  mem_byte_enable256 = '0;
  logic [SL-1:0]  mem_wdata256 = '0, pmem_rdata = '0;
  logic [SL-1:0]  mem_rdata256, pmem_wdata;
  logic [31:0]    pmem_address;
  logic [WI-1:0]  way_sel = '0;
  logic           data_src = 0, addr_src = 0, meta_load = 0, valid_i = 0, dirty_i = 0;
  logic [1:0]     we_mode = 2'd0;
  logic [NW-1:0]  hit_o;
  logic           hit_any, victim_dirty;
  logic [WI-1:0]  hit_way, victim_way;
  logic           flush_req = 0, flush_busy, flush_wb_req, flush_wb_ack = 0, flush_done;
  logic [31:0]    hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_nway_datapath dut (
    .clk(clk), .rst(rst), .address_i(address_i), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256), .mem_wdata256(mem_wdata256),
    .mem_rdata256(mem_rdata256), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
    .pmem_address(pmem_address), .way_sel(way_sel), .data_src(data_src), .we_mode(we_mode),
    .addr_src(addr_src), .meta_load(meta_load), .valid_i(valid_i), .dirty_i(dirty_i),
    .hit_o(hit_o), .hit_any(hit_any), .hit_way(hit_way), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_wb_req(flush_wb_req), .flush_wb_ack(flush_wb_ack), .flush_done(flush_done),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int nvec = 0, nerr = 0;

  // ---------------- reference model ----------------
  bit [SL-1:0] m_data  [NW][NS];
  bit [23:0]   m_tag   [NW][NS];
  bit          m_valid [NW][NS];
  bit          m_dirty [NW][NS];
  bit          m_pv    [NS][WI][NW/2]; // per set/level/prefix: way bit to evict next
  int          m_hits, m_miss;

  function automatic bit [31:0] mk_addr(input bit [23:0] t, input int s);
    bit [2:0] s3;
    s3 = 3'(s);
    return {t, s3, 5'd0};
  endfunction

  function automatic bit [SL-1:0] rand_line();
    bit [SL-1:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic void m_reset();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) begin m_valid[w][s] = 0; m_dirty[w][s] = 0; end
    for (int s = 0; s < NS; s++)
      for (int d = 0; d < WI; d++)
        for (int p = 0; p < NW/2; p++) m_pv[s][d][p] = 0;
    m_hits = 0; m_miss = 0;
  endfunction

  function automatic int m_lookup(input bit [31:0] a);
    for (int w = 0; w < NW; w++)
      if (m_valid[w][a[7:5]] && m_tag[w][a[7:5]] == a[31:8]) return w;
    return -1;
  endfunction

  function automatic void m_touch(input int s, input int w);
    for (int d = 0; d < WI; d++)
      m_pv[s][d][w & ((1 << d) - 1)] = ((w >> d) & 1) == 0;
  endfunction

  function automatic int m_victim(input int s);
    int v = 0;
    for (int w = 0; w < NW; w++) if (!m_valid[w][s]) return w;
    for (int d = 0; d < WI; d++)
      if (m_pv[s][d][v & ((1 << d) - 1)]) v = v | (1 << d);
    return v;
  endfunction

  function automatic int exp_cnt(input int c);
`ifdef DCACHE_PERF_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic refill(input bit [31:0] a, input int w, input bit [SL-1:0] l, input bit d);
    address_i = a; way_sel = WI'(w); data_src = 1; we_mode = 2'd1;
    pmem_rdata = l; meta_load = 1; valid_i = 1; dirty_i = d;
    step();
    we_mode = 2'd0; meta_load = 0; data_src = 0;
    m_data[w][a[7:5]] = l; m_tag[w][a[7:5]] = a[31:8];
    m_valid[w][a[7:5]] = 1; m_dirty[w][a[7:5]] = d;
  endtask

  task automatic access(input bit [31:0] a, output bit o_hit, output int o_way);
    int mw;
    address_i = a; mem_read = 1; #1;
    o_hit = hit_any; o_way = int'(hit_way);
    mw = m_lookup(a);
    if (mw >= 0) begin m_hits++; m_touch(a[7:5], mw); end else m_miss++;
    step(); mem_read = 0; step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; m_reset();
    repeat (2) step();
    rst = 0; address_i = 32'h0000_0040; #1;
    nvec++; if (flush_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", flush_busy); end
    nvec++; if (flush_wb_req !== 1'b0) begin nerr++; $display("FAIL rst_wbreq: got %b want 0", flush_wb_req); end
    nvec++; if (flush_done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", flush_done); end
    nvec++; if (hit_count !== 32'd0) begin nerr++; $display("FAIL rst_hitcnt: got %0d want 0", hit_count); end
    nvec++; if (miss_count !== 32'd0) begin nerr++; $display("FAIL rst_misscnt: got %0d want 0", miss_count); end
    nvec++; if (hit_any !== 1'b0) begin nerr++; $display("FAIL rst_hit: got %b want 0", hit_any); end
    nvec++; if (victim_way !== 2'd0) begin nerr++; $display("FAIL rst_victim: got %0d want 0", victim_way); end
    nvec++; if (victim_dirty !== 1'b0) begin nerr++; $display("FAIL rst_vdirty: got %b want 0", victim_dirty); end
  endtask

  task automatic test_refill();
    bit [SL-1:0] l = rand_line();
    refill(32'h0000_0040, 0, l, 0);
    address_i = 32'h0000_0040; way_sel = 0; addr_src = 0; #1;
    nvec++; if (hit_o !== 4'b0001) begin nerr++; $display("FAIL refill_hit_o: got %b want 0001", hit_o); end
    nvec++; if (hit_way !== 2'd0) begin nerr++; $display("FAIL refill_hitway: got %0d want 0", hit_way); end
    nvec++; if (mem_rdata256 !== l) begin nerr++; $display("FAIL refill_rdata: got %h want %h", mem_rdata256, l); end
    nvec++; if (pmem_wdata !== l) begin nerr++; $display("FAIL refill_pwdata: got %h want %h", pmem_wdata, l); end
    address_i = 32'h1234_5658; #1;
    nvec++; if (pmem_address !== 32'h1234_5640) begin nerr++; $display("FAIL addr_cpu: got %h want 12345640", pmem_address); end
    nvec++; if (hit_any !== 1'b0) begin nerr++; $display("FAIL refill_miss: got %b want 0", hit_any); end
    addr_src = 1; #1;
    nvec++; if (pmem_address !== 32'h0000_0040) begin nerr++; $display("FAIL addr_tag: got %h want 00000040", pmem_address); end
    addr_src = 0;
  endtask

  bit [23:0] ptag [NW];

  task automatic test_plru();
    bit [23:0] base = 24'h10_0000 | 24'($urandom_range(0, 24'h0F_FFF0));
    bit h; int hw, ew, r, ev;
    bit [31:0] a;
    for (int w = 0; w < NW; w++) begin
      ptag[w] = base + 24'(w);
      refill(mk_addr(ptag[w], 2), w, rand_line(), 0);
      ev = m_victim(2); #1;
      nvec++; if (victim_way !== WI'(ev)) begin nerr++; $display("FAIL fill_victim%0d: got %0d want %0d", w, victim_way, ev); end
    end
    for (int w = 0; w < 3; w++) begin
      access(mk_addr(ptag[w], 2), h, hw);
      nvec++; if (hw != w) begin nerr++; $display("FAIL plru_hitway%0d: got %0d want %0d", w, hw, w); end
    end
    ev = m_victim(2); #1;
    nvec++; if (victim_way !== WI'(ev) || ev != 3) begin nerr++; $display("FAIL plru_v3: got %0d want 3 (model %0d)", victim_way, ev); end
    address_i = mk_addr(ptag[3], 2); mem_read = 1;
    step(); mem_read = 0;
    m_hits++; m_touch(2, 3);
    nvec++; if (victim_way !== 2'd0) begin nerr++; $display("FAIL plru_v0: got %0d want 0", victim_way); end
    step();
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, NW);
      a = mk_addr((r < NW) ? ptag[r] : base + 24'd8, 2);
      ew = m_lookup(a);
      access(a, h, hw);
      nvec++; if (h !== (ew >= 0)) begin nerr++; $display("FAIL rnd_hit: got %b want %b", h, ew >= 0); end
      nvec++; if (ew >= 0 && hw != ew) begin nerr++; $display("FAIL rnd_hitway: got %0d want %0d", hw, ew); end
      ev = m_victim(2); #1;
      nvec++; if (victim_way !== WI'(ev)) begin nerr++; $display("FAIL rnd_victim: got %0d want %0d", victim_way, ev); end
    end
  endtask

  task automatic test_back_to_back();
    bit [31:0] a0 = mk_addr(ptag[2], 2), a1 = mk_addr(ptag[0], 2);
    int ev;
    address_i = a0; mem_read = 1; #1;
    nvec++; if (hit_way !== 2'd2) begin nerr++; $display("FAIL b2b_hw0: got %0d want 2", hit_way); end
    m_hits++; m_touch(2, 2);
    step(); address_i = a1; #1;
    nvec++; if (hit_way !== 2'd0) begin nerr++; $display("FAIL b2b_hw1: got %0d want 0", hit_way); end
    m_touch(2, 0);
    step(); mem_read = 0; step();
    ev = m_victim(2); #1;
    nvec++; if (victim_way !== WI'(ev)) begin nerr++; $display("FAIL b2b_victim: got %0d want %0d", victim_way, ev); end
    nvec++; if (hit_count !== 32'(exp_cnt(m_hits))) begin nerr++; $display("FAIL b2b_hitcnt: got %0d want %0d", hit_count, exp_cnt(m_hits)); end
  endtask

  task automatic test_mbe();
    bit [SL-1:0] src;
    bit [SM-1:0] mbe;
    int w;
    for (int it = 0; it < 5; it++) begin
      w    = (it == 0) ? 1 : $urandom_range(0, NW - 1);
      mbe  = (it == 0) ? 32'h0000_000F : 32'($urandom);
      src  = (it == 0) ? {32{8'hA5}} : rand_line();
      data_src = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      address_i = mk_addr(ptag[w], 2); way_sel = WI'(w); we_mode = 2'd2;
      mem_byte_enable256 = mbe;
      if (data_src) begin pmem_rdata = src; mem_wdata256 = ~src; end
      else begin mem_wdata256 = src; pmem_rdata = ~src; end
      step(); we_mode = 2'd0; data_src = 0;
      for (int b = 0; b < SM; b++) if (mbe[b]) m_data[w][2][8*b +: 8] = src[8*b +: 8];
      for (int v = 0; v < NW; v++) begin
        way_sel = WI'(v); #1;
        nvec++; if (mem_rdata256 !== m_data[v][2]) begin nerr++; $display("FAIL mbe_it%0d_way%0d: got %h want %h", it, v, mem_rdata256, m_data[v][2]); end
      end
    end
  endtask

  task automatic test_flush();
    bit [31:0] eq_a[$];
    bit [SL-1:0] eq_d[$];
    int eq_w[$], eq_s[$];
    int wb, dn, cyc;
    bit [23:0] ta = 24'($urandom) | 24'h80_0000, tb = 24'($urandom) | 24'h40_0000;
    refill(mk_addr(ta, 0), 1, rand_line(), 1);
    refill(mk_addr(tb, 7), 3, rand_line(), 1);
    for (int pass = 0; pass < 2; pass++) begin
      eq_a.delete(); eq_d.delete(); eq_w.delete(); eq_s.delete();
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NW; w++)
          if (m_valid[w][s] && m_dirty[w][s]) begin
            eq_a.push_back(mk_addr(m_tag[w][s], s)); eq_d.push_back(m_data[w][s]);
            eq_w.push_back(w); eq_s.push_back(s);
          end
      if (pass == 0) begin
        nvec++; if (eq_a.size() != 2 || eq_a[0] != mk_addr(ta, 0) || eq_a[1] != mk_addr(tb, 7)) begin
          nerr++; $display("FAIL flush_plan: got %0d lines want 2", eq_a.size()); end
      end
      flush_req = 1; step(); flush_req = 0;
      address_i = mk_addr(ta, 0); #1;
      nvec++; if (flush_busy !== 1'b1) begin nerr++; $display("FAIL flush_busy%0d: got %b want 1", pass, flush_busy); end
      nvec++; if (hit_any !== 1'b0) begin nerr++; $display("FAIL flush_hitmask%0d: got %b want 0", pass, hit_any); end
      wb = 0; dn = 0; cyc = 0;
      while (cyc < 200 && dn == 0) begin
        if (flush_wb_req) begin
          nvec++;
          if (wb >= eq_a.size()) begin nerr++; $display("FAIL flush_extra_wb: got %h want none", pmem_address); end
          else if (pmem_address !== eq_a[wb] || pmem_wdata !== eq_d[wb]) begin
            nerr++; $display("FAIL flush_wb%0d: got addr %h want %h", wb, pmem_address, eq_a[wb]); end
          if (wb < eq_a.size()) m_dirty[eq_w[wb]][eq_s[wb]] = 0;
          flush_wb_ack = 1; step(); flush_wb_ack = 0; wb++;
        end else if (flush_done) begin
          dn = 1; step();
        end else step();
        cyc++;
      end
      nvec++; if (dn != 1) begin nerr++; $display("FAIL flush_timeout%0d: got no done want done", pass); end
      nvec++; if (wb != eq_a.size()) begin nerr++; $display("FAIL flush_wbcnt%0d: got %0d want %0d", pass, wb, eq_a.size()); end
      nvec++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
        nerr++; $display("FAIL flush_end%0d: got busy %b done %b want 0 0", pass, flush_busy, flush_done); end
    end
  endtask

  task automatic test_reset_mid_flush();
    bit [31:0] a = mk_addr(24'h00_ABCD, 4);
    int cyc = 0, dn = 0;
    refill(a, 0, rand_line(), 1);
    flush_req = 1; step(); flush_req = 0;
    while (!flush_wb_req && cyc < 50) begin step(); cyc++; end
    nvec++; if (flush_wb_req !== 1'b1) begin nerr++; $display("FAIL rstfl_wb: got %b want 1", flush_wb_req); end
    #2 rst = 1; #1;
    nvec++; if (flush_busy !== 1'b0) begin nerr++; $display("FAIL rstfl_busy: got %b want 0", flush_busy); end
    nvec++; if (flush_wb_req !== 1'b0) begin nerr++; $display("FAIL rstfl_wbreq: got %b want 0", flush_wb_req); end
    step(); rst = 0; m_reset();
    address_i = a;
    for (int i = 0; i < 4; i++) begin if (flush_done) dn++; step(); end
    nvec++; if (dn != 0) begin nerr++; $display("FAIL rstfl_done: got %0d pulses want 0", dn); end
    nvec++; if (hit_any !== 1'b0) begin nerr++; $display("FAIL rstfl_valid: got %b want 0", hit_any); end
    nvec++; if (victim_dirty !== 1'b0 || victim_way !== 2'd0) begin
      nerr++; $display("FAIL rstfl_victim: got %b/%0d want 0/0", victim_dirty, victim_way); end
  endtask

  task automatic test_perf();
    bit [31:0] a = mk_addr(24'h00_1234, 1);
    bit h; int hw;
    refill(a, 0, rand_line(), 0);
    for (int i = 0; i < 3; i++) access(a, h, hw);
    access(mk_addr(24'h00_5555, 1), h, hw);
    access(mk_addr(24'h00_6666, 5), h, hw);
    nvec++; if (hit_count !== 32'(exp_cnt(m_hits))) begin nerr++; $display("FAIL perf_hits: got %0d want %0d", hit_count, exp_cnt(m_hits)); end
    nvec++; if (miss_count !== 32'(exp_cnt(m_miss))) begin nerr++; $display("FAIL perf_miss: got %0d want %0d", miss_count, exp_cnt(m_miss)); end
    nvec++; if (hit_count !== 32'(exp_cnt(3)) || miss_count !== 32'(exp_cnt(2))) begin
      nerr++; $display("FAIL perf_plan: got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_cnt(3), exp_cnt(2)); end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_plru();
    test_back_to_back();
    test_mbe();
    test_flush();
    test_reset_mid_flush();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dcache_nway_datapath.md
Name: dcache_nway_datapath

Overview:
- Parametrised N-way set-associative D-cache datapath: data, tag, valid, dirty and tree-PLRU arrays; hit detection; victim selection; line muxing toward the CPU bus adaptor and the cacheline adaptor.
- Adds a built-in flush sequencer that walks every set and writes back dirty lines.
- Sits between the D-cache controller FSM and the bus/cacheline adaptors; the controller steers it per way.

Parameters:
S_OFFSET, 5, byte-offset bits; line = 2**S_OFFSET bytes
S_INDEX, 3, set-index bits; NUM_SETS = 2**S_INDEX
NUM_WAYS, 4, associativity; power of two, >= 2
Derived (localparam, not overridable): S_TAG = 32-S_OFFSET-S_INDEX, S_MASK = 2**S_OFFSET, S_LINE = 8*S_MASK, W_IDX = $clog2(NUM_WAYS)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
address_i  in  32  CPU address
mem_read  in  1  CPU read request
mem_write  in  1  CPU write request
mem_byte_enable256  in  S_MASK  byte enables for CPU line write
mem_wdata256  in  S_LINE  CPU write line
mem_rdata256  out  S_LINE  selected way's line
pmem_rdata  in  S_LINE  refill line from memory
pmem_wdata  out  S_LINE  writeback line (same as mem_rdata256)
pmem_address  out  32  line-aligned memory address
way_sel  in  W_IDX  way targeted by muxes and loads
data_src  in  1  data-in select: 0 = CPU, 1 = memory
we_mode  in  2  write-enable mode for way_sel: zeros / ones / mbe
addr_src  in  1  0 = {address_i[31:S_OFFSET],0}; 1 = {tag[way_sel],set,0}
meta_load  in  1  write valid_i/dirty_i/tag into way_sel at current set
valid_i  in  1  valid value to write
dirty_i  in  1  dirty value to write
hit_o  out  NUM_WAYS  per-way hit
hit_any  out  1  OR of hit_o
hit_way  out  W_IDX  encoded hitting way
victim_way  out  W_IDX  replacement candidate
victim_dirty  out  1  victim valid and dirty
flush_req  in  1  start flush (pulse)
flush_busy  out  1  flush in progress
flush_wb_req  out  1  flush line on pmem_address/pmem_wdata awaits writeback
flush_wb_ack  in  1  writeback of presented line complete
flush_done  out  1  one-cycle pulse at flush completion
hit_count  out  32  see Optional Feature
miss_count  out  32  see Optional Feature

Behaviour:
- Arrays
  - Flop-based, combinational read at current set.
  - Writes take effect on the rising edge.
  - On rst: valid, dirty and PLRU arrays clear to 0 asynchronously. Data and tag arrays are not reset.
- Set selection
  - set = flush_set when flush_busy, else address_i[S_OFFSET+S_INDEX-1:S_OFFSET].
- Hit detection
  - hit_o[w] = valid[w] && tag[w] == address_i tag.
  - hit_o is forced to 0 while flush_busy.
  - hit_way = lowest hitting index; 0 when no hit.
- Writes
  - we_mode applies only to way_sel: zeros = no write, ones = full line, mbe = mem_byte_enable256.
  - Other ways are never written in the same cycle.
- PLRU
  - Tree of NUM_WAYS-1 bits per set.
  - Update is registered: when (mem_read | mem_write) && hit_any, the set and new bits are captured and committed next cycle.
  - If the current set equals the pending set, the read is forwarded from the pending bits.
  - No update while flush_busy.
- Victim selection
  - victim_way = lowest-index invalid way if any; else the PLRU tree victim.
  - Combinational.
- Flush FSM: IDLE, SCAN, WB, DONE. Reset state IDLE, flush_set = 0.
  - IDLE: on flush_req -> SCAN with flush_set = 0. flush_req is ignored outside IDLE.
  - SCAN: lowest way with valid && dirty at flush_set -> latch as flush_way, go to WB. If none: last set -> DONE, else flush_set++.
  - WB: flush_wb_req = 1; pmem_address = {tag[flush_way], flush_set, 0}; pmem_wdata = data[flush_way]. On flush_wb_ack, clear dirty[flush_way] and return to SCAN on the same set.
  - DONE: flush_done = 1 for one cycle, then IDLE.
  - flush_busy = state != IDLE.
  - During flush, way_sel/addr_src are overridden internally; CPU requests and meta_load/we_mode are ignored.
- Output reset values: flush_busy, flush_wb_req, flush_done, hit_count, miss_count = 0. hit_o/victim outputs reflect the cleared arrays.
- Reset mid-flush: immediate return to IDLE, no flush_done pulse; dirty bits clear with the arrays.
- Simultaneous hit and flush_req in IDLE: the pending PLRU update still commits; flush starts next cycle.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- When defined:
  - Request start = (mem_read | mem_write) rising relative to the previous cycle, flush not busy.
  - At request start, hit_count increments if hit_any, else miss_count increments.
  - Counters are 32-bit, saturate at 0xFFFF_FFFF, and clear on rst.
- When undefined: ports remain and are tied to 0; no counter flops.

Decomposition:
- Shared package dcache_pkg:
  - we_mode_e (WE_ZEROS = 0, WE_ONES = 1, WE_MBE = 2)
  - data_src_e, addr_src_e, flush_state_e
- Sub-module dcache_plru_tree, parametrised by NUM_WAYS:
  - combinational next-bits from accessed way
  - victim from current bits

Test Plan:
- Reset, read 0x0000_0040 -> hit_any = 0, victim_way = 0. Refill way 0 (data_src = 1, WE_ONES, meta_load valid = 1) -> re-read gives hit_o = 4'b0001, mem_rdata256 = refill line.
- Fill all 4 ways of set 2, hit ways 0,1,2 in order -> victim_way = 3. Hit way 3 -> victim_way = 0 next cycle.
- Write via WE_MBE, byte enables 0x0000_000F, data 0xA5 bytes -> only bytes 0-3 of way_sel change; other ways untouched.
- Dirty way 1 at set 0 and way 3 at set 7, flush_req -> two flush_wb_req, at {tag,0,0} then {tag,7,0}. Ack each -> flush_done pulse after set 7; all dirty bits 0.
- Assert rst while flush is in WB -> flush_busy = 0 immediately, no flush_done, valid/dirty = 0.
- DCACHE_PERF_CNT_EN defined: 3 hits and 2 misses -> hit_count = 3, miss_count = 2. Undefined -> both 0.
